// File: rtl/score_keeper.sv
// BCD score, lives and high-score tracker between the collision logic and the HUD.
// Hits are added one BCD digit per cycle; a small game FSM sequences idle/play/over.
module score_keeper #(
  parameter int SCORE_DIGITS = 4,
  parameter int LIVES_W      = 3,
  parameter int START_LIVES  = 3,
  parameter int MAX_LIVES    = 7,
  parameter logic [4*SCORE_DIGITS-1:0] PTS0     = 'h10,
  parameter logic [4*SCORE_DIGITS-1:0] PTS1     = 'h20,
  parameter logic [4*SCORE_DIGITS-1:0] PTS2     = 'h30,
  parameter logic [4*SCORE_DIGITS-1:0] PTS3     = 'h150,
  parameter logic [4*SCORE_DIGITS-1:0] BONUS_AT = 'h1500
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      new_game,
  input  logic                      hit_valid,
  input  logic [1:0]                hit_type,
  output logic                      hit_ready,
  input  logic                      player_hit,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] high_score,
  output logic [LIVES_W-1:0]        lives,
  output logic                      game_over,
  output logic                      extra_life,
  output logic [1:0]                dbg_game_state,
  output logic                      dbg_add_state
);

  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [SW-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  // Handshake: a hit transfers on a rising edge where hit_valid && hit_ready;
  // hit_type must be held while hit_valid is high and hit_ready is low.
  typedef enum logic [1:0] {G_IDLE = 2'd0, G_PLAY = 2'd1, G_OVER = 2'd2} game_e;
  typedef enum logic {A_WAIT = 1'b0, A_ADD = 1'b1} add_e;

  game_e              game_q, game_d;
  add_e               add_q, add_d;
  logic [SW-1:0]      score_q, score_d, high_q, high_d;
  logic [SW-1:0]      acc_q, acc_d, addend_q, addend_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               bonus_done_q, bonus_done_d;
  logic               extra_q, extra_d;

  logic [SW-1:0]      pts_sel, acc_upd, sum_final;
  logic [3:0]         acc_digit, add_digit, dval;
  logic [4:0]         dsum;
  logic               dcarry, last_digit, commit, bonus, accept;
  logic [LIVES_W-1:0] lives_inc;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      game_q       <= G_IDLE;
      add_q        <= A_WAIT;
      score_q      <= '0;
      high_q       <= '0;
      acc_q        <= '0;
      addend_q     <= '0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      lives_q      <= '0;
      bonus_done_q <= 1'b0;
      extra_q      <= 1'b0;
    end else begin
      game_q       <= game_d;
      add_q        <= add_d;
      score_q      <= score_d;
      high_q       <= high_d;
      acc_q        <= acc_d;
      addend_q     <= addend_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      lives_q      <= lives_d;
      bonus_done_q <= bonus_done_d;
      extra_q      <= extra_d;
    end
  end

  always_comb begin
    case (hit_type)
      2'd0:    pts_sel = PTS0;
      2'd1:    pts_sel = PTS1;
      2'd2:    pts_sel = PTS2;
      default: pts_sel = PTS3;
    endcase
  end

  // One BCD digit of the running sum; carry out of the top digit saturates.
  always_comb begin
    acc_digit  = acc_q[idx_q*4 +: 4];
    add_digit  = addend_q[idx_q*4 +: 4];
    dsum       = {1'b0, acc_digit} + {1'b0, add_digit} + {4'd0, carry_q};
    dcarry     = (dsum > 5'd9);
    dval       = dcarry ? (dsum[3:0] + 4'd6) : dsum[3:0];
    acc_upd    = acc_q;
    acc_upd[idx_q*4 +: 4] = dval;
    sum_final  = dcarry ? ALL_NINES : acc_upd;
    last_digit = (idx_q == IDX_W'(SCORE_DIGITS - 1));
    commit     = (add_q == A_ADD) && last_digit;
    bonus      = commit && !bonus_done_q && (score_q < BONUS_AT) && (sum_final >= BONUS_AT);
    accept     = hit_valid && hit_ready;
  end

  always_comb begin
    game_d       = game_q;
    add_d        = add_q;
    score_d      = score_q;
    high_d       = high_q;
    acc_d        = acc_q;
    addend_d     = addend_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    bonus_done_d = bonus_done_q || bonus;
    extra_d      = bonus;

    case (add_q)
      A_WAIT: begin
        if (accept) begin
          add_d    = A_ADD;
          acc_d    = score_q;
          addend_d = pts_sel;
          idx_d    = '0;
          carry_d  = 1'b0;
        end
      end
      default: begin
        acc_d   = acc_upd;
        carry_d = dcarry;
        idx_d   = idx_q + IDX_W'(1);
        if (last_digit) begin
          add_d   = A_WAIT;
          score_d = sum_final;
        end
      end
    endcase

    // Bonus is applied and saturated before a same-cycle life loss.
    if (bonus && (lives_q >= LIVES_W'(MAX_LIVES))) lives_inc = LIVES_W'(MAX_LIVES);
    else if (bonus)                                lives_inc = lives_q + LIVES_W'(1);
    else                                           lives_inc = lives_q;
    if ((game_q == G_PLAY) && player_hit && (lives_inc != '0)) lives_d = lives_inc - LIVES_W'(1);
    else                                                         lives_d = lives_inc;

    case (game_q)
      G_PLAY: begin
        if ((lives_q == '0) && (add_q == A_WAIT)) begin
          game_d = G_OVER;
          if (score_q > high_q) high_d = score_q;
        end
      end
      default: begin
        if (new_game) begin
          game_d       = G_PLAY;
          score_d      = '0;
          lives_d      = LIVES_W'(START_LIVES);
          bonus_done_d = 1'b0;
        end
      end
    endcase
  end

  // A dead player waiting for a commit must not take further hits.
  always_comb begin
    hit_ready      = (game_q == G_PLAY) && (add_q == A_WAIT) && (lives_q != '0);
    game_over      = (game_q == G_OVER);
    score          = score_q;
    high_score     = high_q;
    lives          = lives_q;
    extra_life     = extra_q;
    dbg_game_state = game_q;
    dbg_add_state  = add_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table plus hand-written game sequences, with an
// expected-score queue filled at hit acceptance and drained at commit.
module tb_score_keeper;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         new_game = 1'b0;
  logic         hit_valid = 1'b0;
  logic [1:0]   hit_type = 2'd0;
  logic         player_hit = 1'b0;
  logic         hit_ready, game_over, extra_life, dbg_add_state;
  logic [W-1:0] score, high_score;
  logic [2:0]   lives;
  logic [1:0]   dbg_game_state;
  logic         hit_ready7, game_over7, extra_life7, dbg_add_state7;
  logic [W-1:0] score7, high_score7;
  logic [2:0]   lives7;
  logic [1:0]   dbg_game_state7;

  score_keeper u_dut (
    .clk(clk), .arst_n(arst_n), .new_game(new_game), .hit_valid(hit_valid),
    .hit_type(hit_type), .hit_ready(hit_ready), .player_hit(player_hit),
    .score(score), .high_score(high_score), .lives(lives), .game_over(game_over),
    .extra_life(extra_life), .dbg_game_state(dbg_game_state), .dbg_add_state(dbg_add_state)
  );

  // Second instance starting at the lives ceiling, to reach the saturation case.
  score_keeper #(.START_LIVES(7)) u_dut7 (
    .clk(clk), .arst_n(arst_n), .new_game(new_game), .hit_valid(hit_valid),
    .hit_type(hit_type), .hit_ready(hit_ready7), .player_hit(player_hit),
    .score(score7), .high_score(high_score7), .lives(lives7), .game_over(game_over7),
    .extra_life(extra_life7), .dbg_game_state(dbg_game_state7), .dbg_add_state(dbg_add_state7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   typ;
    logic [W-1:0] exp_score;
    logic         exp_bonus;
  } vec_t;

  vec_t         vecs[23];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pts_tab[4];
  logic [W-1:0] score_m;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] b);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] b = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      b[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [1:0] t);
    int s = bcd2int(a) + bcd2int(pts_tab[t]);
    if (s > 9999) s = 9999;
    return int2bcd(s);
  endfunction

  // Entered and left on a falling edge. ph_at >= 0 pulses player_hit during that ADD cycle.
  task automatic do_hit(input logic [1:0] t, input logic [W-1:0] exp_s, input logic exp_b,
                        input int ph_at, input logic chk_rdy);
    int guard = 0;
    logic [W-1:0] old, exp;
    while (!hit_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("hit_ready_wait", 32'(hit_ready), 32'd1);
    old = score_m;
    hit_valid = 1'b1;
    hit_type  = t;
    exp_q.push_back(exp_s);
    @(negedge clk);
    hit_valid = 1'b0;
    for (int i = 0; i < D; i++) begin
      chk("busy_ready", 32'(hit_ready), 32'd0);
      chk("no_partial", 32'(score), 32'(old));
      player_hit = (i == ph_at);
      @(negedge clk);
    end
    player_hit = 1'b0;
    if (chk_rdy) chk("ready_after_commit", 32'(hit_ready), 32'd1);
    chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("score", 32'(score), 32'(exp));
    chk("extra_life", 32'(extra_life), 32'(exp_b));
    chk("play_at_commit", 32'(game_over), 32'd0);
    score_m = exp;
    @(negedge clk);
    chk("extra_pulse_end", 32'(extra_life), 32'd0);
  endtask

  task automatic hit_m(input logic [1:0] t);
    do_hit(t, model_add(score_m, t), 1'b0, -1, 1'b1);
  endtask

  task automatic lose_life(input logic [2:0] exp_lives);
    player_hit = 1'b1;
    @(negedge clk);
    player_hit = 1'b0;
    chk("lives_after_hit", 32'(lives), 32'(exp_lives));
  endtask

  task automatic start_game;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_ready", 32'(hit_ready), 32'd1);
    chk("ng_score", 32'(score), 32'd0);
    chk("ng_lives", 32'(lives), 32'd3);
    chk("ng_over", 32'(game_over), 32'd0);
    score_m = '0;
  endtask

  task automatic expect_over(input logic [W-1:0] exp_high);
    chk("over_delay", 32'(game_over), 32'd0);
    @(negedge clk);
    chk("game_over", 32'(game_over), 32'd1);
    chk("high_score", 32'(high_score), 32'(exp_high));
    chk("over_ready", 32'(hit_ready), 32'd0);
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    pts_tab[0] = 16'h0010; pts_tab[1] = 16'h0020; pts_tab[2] = 16'h0030; pts_tab[3] = 16'h0150;
    vecs[0]  = '{2'd2, 16'h0030, 1'b0}; vecs[1]  = '{2'd0, 16'h0040, 1'b0};
    vecs[2]  = '{2'd1, 16'h0060, 1'b0}; vecs[3]  = '{2'd0, 16'h0070, 1'b0};
    vecs[4]  = '{2'd1, 16'h0090, 1'b0}; vecs[5]  = '{2'd0, 16'h0100, 1'b0};
    vecs[6]  = '{2'd3, 16'h0250, 1'b0}; vecs[7]  = '{2'd3, 16'h0400, 1'b0};
    vecs[8]  = '{2'd2, 16'h0430, 1'b0}; vecs[9]  = '{2'd3, 16'h0580, 1'b0};
    vecs[10] = '{2'd3, 16'h0730, 1'b0}; vecs[11] = '{2'd3, 16'h0880, 1'b0};
    vecs[12] = '{2'd3, 16'h1030, 1'b0}; vecs[13] = '{2'd3, 16'h1180, 1'b0};
    vecs[14] = '{2'd3, 16'h1330, 1'b0}; vecs[15] = '{2'd1, 16'h1350, 1'b0};
    vecs[16] = '{2'd2, 16'h1380, 1'b0}; vecs[17] = '{2'd1, 16'h1400, 1'b0};
    vecs[18] = '{2'd1, 16'h1420, 1'b0}; vecs[19] = '{2'd1, 16'h1440, 1'b0};
    vecs[20] = '{2'd1, 16'h1460, 1'b0}; vecs[21] = '{2'd1, 16'h1480, 1'b0};
    vecs[22] = '{2'd1, 16'h1500, 1'b1};
    score_m = '0;

    // Reset values, then hit_ready must stay low until new_game.
    @(negedge clk);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_high", 32'(high_score), 32'd0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_extra", 32'(extra_life), 32'd0);
    chk("rst_ready", 32'(hit_ready), 32'd0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(hit_ready), 32'd0);

    // Game 1: ends at 0200 with the last life lost mid-ADD.
    start_game();
    hit_m(2'd3);
    for (int i = 0; i < 4; i++) hit_m(2'd0);
    lose_life(3'd2);
    lose_life(3'd1);
    do_hit(2'd0, 16'h0200, 1'b0, 1, 1'b0);
    chk("g1_over", 32'(game_over), 32'd1);
    chk("g1_high", 32'(high_score), 32'h0200);
    chk("g1_lives", 32'(lives), 32'd0);

    // Game 2: new_game in PLAY ignored, lower final score keeps high score.
    start_game();
    chk("g2_high_kept", 32'(high_score), 32'h0200);
    hit_m(2'd1);
    hit_m(2'd1);
    lose_life(3'd2);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_in_play_score", 32'(score), 32'h0040);
    chk("ng_in_play_lives", 32'(lives), 32'd2);
    chk("ng_in_play_ready", 32'(hit_ready), 32'd1);
    for (int i = 0; i < 3; i++) hit_m(2'd1);
    chk("g2_score", 32'(score), 32'h0100);
    lose_life(3'd1);
    lose_life(3'd0);
    expect_over(16'h0200);

    // Game 3: vector table up to the bonus, then saturation.
    start_game();
    foreach (vecs[i]) do_hit(vecs[i].typ, vecs[i].exp_score, vecs[i].exp_bonus, -1, 1'b1);
    chk("bonus_lives", 32'(lives), 32'd4);
    while (score_m < 16'h9990) begin
      if (bcd2int(score_m) + 150 <= 9990) hit_m(2'd3);
      else                                hit_m(2'd0);
    end
    chk("pre_sat", 32'(score), 32'h9990);
    do_hit(2'd3, 16'h9999, 1'b0, -1, 1'b1);
    do_hit(2'd0, 16'h9999, 1'b0, -1, 1'b1);
    chk("no_second_bonus", 32'(lives), 32'd4);
    lose_life(3'd3);
    lose_life(3'd2);
    lose_life(3'd1);
    lose_life(3'd0);
    expect_over(16'h9999);

    // Asynchronous reset in the middle of an add.
    start_game();
    hit_valid = 1'b1;
    hit_type  = 2'd2;
    @(negedge clk);
    hit_valid = 1'b0;
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_high", 32'(high_score), 32'd0);
    chk("arst_lives", 32'(lives), 32'd0);
    chk("arst_over", 32'(game_over), 32'd0);
    chk("arst_extra", 32'(extra_life), 32'd0);
    chk("arst_ready", 32'(hit_ready), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(hit_ready), 32'd0);
      chk("post_rst_score", 32'(score), 32'd0);
    end

    // Game 4: bonus and player_hit on the commit cycle, at and below the ceiling.
    start_game();
    chk("lives7_start", 32'(lives7), 32'd7);
    for (int i = 0; i < 9; i++) hit_m(2'd3);
    hit_m(2'd2);
    for (int i = 0; i < 5; i++) hit_m(2'd1);
    chk("g4_pre", 32'(score), 32'h1480);
    do_hit(2'd1, 16'h1500, 1'b1, D - 1, 1'b1);
    chk("same_cycle_lives", 32'(lives), 32'd3);
    chk("same_cycle_lives7", 32'(lives7), 32'd6);
    chk("score7", 32'(score7), 32'h1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
